// File: rtl/pea_div_arbiter.sv
// Round-robin front end that shares one external iterative divider among the PEA's PEs.
// Divide-by-zero, signed overflow and unsupported opcodes are answered without the divider.
module pea_div_arbiter #(
  parameter int unsigned N_REQ  = 16,
  parameter int unsigned N_BITS = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ-1:0][OP_W-1:0]   req_op_i,
  input  logic [N_REQ-1:0][N_BITS-1:0] req_a_i,
  input  logic [N_REQ-1:0][N_BITS-1:0] req_b_i,
  output logic [N_REQ-1:0]             grant_o,
  output logic [N_REQ-1:0]             rsp_valid_o,
  output logic [N_BITS-1:0]            rsp_data_o,
  output logic                         rsp_err_o,
  output logic                         busy_o,
  output logic                         div_valid_o,
  input  logic                         div_ready_i,
  output logic [N_BITS-1:0]            div_a_o,
  output logic [N_BITS-1:0]            div_b_o,
  output logic                         div_signed_o,
  output logic                         div_rem_o,
  input  logic                         div_done_i,
  input  logic [N_BITS-1:0]            div_result_i
);

  localparam int unsigned       IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [OP_W-1:0]   OP_DIV   = OP_W'(4'b1011);
  localparam logic [OP_W-1:0]   OP_DIVU  = OP_W'(4'b1100);
  localparam logic [OP_W-1:0]   OP_REM   = OP_W'(4'b1110);
  localparam logic [N_BITS-1:0] INT_MIN  = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  win_q;
  logic [IDX_W-1:0]  win_idx;
  logic              any_req;
  logic [OP_W-1:0]   win_op;
  logic [N_BITS-1:0] win_a;
  logic [N_BITS-1:0] win_b;
  logic              is_div;
  logic              is_divu;
  logic              is_rem;
  logic              op_ok;
  logic              spc_hit;
  logic              spc_err;
  logic [N_BITS-1:0] spc_data;

  // First set request after the last winner, wrapping modulo N_REQ.
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!any_req && req_valid_i[IDX_W'((32'(ptr_q) + i) % N_REQ)]) begin
        any_req = 1'b1;
        win_idx = IDX_W'((32'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign win_op = req_op_i[win_idx];
  assign win_a  = req_a_i[win_idx];
  assign win_b  = req_b_i[win_idx];

  // Cases resolved locally: bad opcode, zero divisor, INT_MIN / -1.
  always_comb begin
    is_div   = (win_op == OP_DIV);
    is_divu  = (win_op == OP_DIVU);
    is_rem   = (win_op == OP_REM);
    op_ok    = is_div | is_divu | is_rem;
    spc_hit  = 1'b1;
    spc_err  = 1'b0;
    spc_data = '0;
    if (!op_ok) begin
      spc_err = 1'b1;
    end else if (win_b == '0) begin
      spc_data = is_rem ? win_a : '1;
    end else if (!is_divu && (win_a == INT_MIN) && (win_b == '1)) begin
      spc_data = is_rem ? '0 : INT_MIN;
    end else begin
      spc_hit = 1'b0;
    end
  end

  // Grant is Mealy so the winner's operands are captured in the grant cycle.
  assign grant_o = ((state_q == S_IDLE) && any_req && !rst_i) ? (ONE_HOT0 << win_idx) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDX_W'(N_REQ - 1);
      win_q        <= '0;
      rsp_valid_o  <= '0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
      busy_o       <= 1'b0;
      div_valid_o  <= 1'b0;
      div_a_o      <= '0;
      div_b_o      <= '0;
      div_signed_o <= 1'b0;
      div_rem_o    <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            ptr_q        <= win_idx;
            win_q        <= win_idx;
            div_a_o      <= win_a;
            div_b_o      <= win_b;
            div_signed_o <= is_div | is_rem;
            div_rem_o    <= is_rem;
            busy_o       <= 1'b1;
            if (spc_hit) begin
              rsp_valid_o <= ONE_HOT0 << win_idx;
              rsp_data_o  <= spc_data;
              rsp_err_o   <= spc_err;
              state_q     <= S_RESP;
            end else begin
              div_valid_o <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (div_ready_i) begin
            div_valid_o <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_done_i) begin
            rsp_valid_o <= ONE_HOT0 << win_q;
            rsp_data_o  <= div_result_i;
            rsp_err_o   <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pea_div_arbiter.sv
// Scoreboard bench for pea_div_arbiter: random PE requests and a behavioural divider,
// checked against a reference of the arbitration and special-case rules.
module tb_pea_div_arbiter;

  localparam int N_REQ = 16;
  localparam logic [3:0]  OP_DIV  = 4'b1011;
  localparam logic [3:0]  OP_DIVU = 4'b1100;
  localparam logic [3:0]  OP_REM  = 4'b1110;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic                    clk = 1'b0;
  logic                    rst_i = 1'b1;
  logic [N_REQ-1:0]        req_valid_i = '0;
  logic [N_REQ-1:0][3:0]   req_op_i = '0;
  logic [N_REQ-1:0][31:0]  req_a_i = '0;
  logic [N_REQ-1:0][31:0]  req_b_i = '0;
  logic [N_REQ-1:0]        grant_o;
  logic [N_REQ-1:0]        rsp_valid_o;
  logic [31:0]             rsp_data_o;
  logic                    rsp_err_o;
  logic                    busy_o;
  logic                    div_valid_o;
  logic                    div_ready_i = 1'b1;
  logic [31:0]             div_a_o;
  logic [31:0]             div_b_o;
  logic                    div_signed_o;
  logic                    div_rem_o;
  logic                    div_done_i = 1'b0;
  logic [31:0]             div_result_i = '0;

  pea_div_arbiter #(.N_REQ(N_REQ), .N_BITS(32), .OP_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .grant_o(grant_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_signed_o(div_signed_o), .div_rem_o(div_rem_o),
    .div_done_i(div_done_i), .div_result_i(div_result_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] data;
    logic        special;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        rem;
    int          gcyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_cur;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          m_ptr = N_REQ - 1;
  logic        m_idle = 1'b1;
  int          rsp_cyc = -100;
  int          done_cyc = -100;
  int          busy_cnt = 0;
  logic        after_rst = 1'b0;
  logic        prev_dv = 1'b0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;
  int          last_gnt_cyc = -100;
  int          last_gnt_idx = -1;
  logic        div_pend = 1'b0;
  int          div_done_at = 0;
  logic [31:0] div_res = '0;
  int          lat_fixed = 8;
  logic        ready_rand = 1'b0;
  int          ready_block_until = 0;
  int          bp_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic flag(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int i = 1; i <= N_REQ; i++) begin
      if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    end
    return -1;
  endfunction

  // Reference result: {err, data} straight from the opcode rules.
  function automatic logic [32:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: return (b == 0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
      OP_DIV: begin
        if (b == 0) return {1'b0, 32'hFFFF_FFFF};
        else if (ovf) return {1'b0, INT_MIN};
        else return {1'b0, 32'($signed(a) / $signed(b))};
      end
      OP_REM: begin
        if (b == 0) return {1'b0, a};
        else if (ovf) return 33'd0;
        else return {1'b0, 32'($signed(a) % $signed(b))};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // External divider behaviour; nonsense operands give a poison value.
  function automatic logic [31:0] dmodel(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic rem);
    if (b == 0 || (sgn && a == INT_MIN && b == 32'hFFFF_FFFF)) return 32'hDEAD_BEEF;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  // Divider environment: ready (optionally blocked/random) and delayed done pulse.
  always @(posedge clk) begin
    #1;
    div_ready_i  = (cyc < ready_block_until) ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    div_done_i   = div_pend && (cyc == div_done_at);
    div_result_i = div_done_i ? div_res : $urandom;
  end

  // Monitor: model update, scoreboard push on grant, pop and compare on response.
  always @(negedge clk) begin
    if (rst_i) begin
      sb.delete();
      m_ptr = N_REQ - 1; m_idle = 1'b1; rsp_cyc = -100; busy_cnt = 0;
      prev_dv = 1'b0; last_data = '0; last_err = 1'b0; after_rst = 1'b1;
    end else begin
      int w;
      logic [N_REQ-1:0] exp_g;
      if (after_rst) begin
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        chk("rst_div_valid", 64'(div_valid_o), 64'd0);
        chk("rst_div_ops", {div_a_o, div_b_o}, 64'd0);
        chk("rst_div_flags", 64'({div_signed_o, div_rem_o}), 64'd0);
        after_rst = 1'b0;
      end
      if (!m_idle && rsp_cyc == cyc - 1) m_idle = 1'b1;
      chk("busy", 64'(busy_o), 64'(!m_idle));

      exp_g = '0;
      w = -1;
      if (m_idle && |req_valid_i) begin
        w = rr_pick(req_valid_i, m_ptr);
        exp_g = N_REQ'(1) << w;
      end
      chk("grant", 64'(grant_o), 64'(exp_g));
      if (w >= 0) begin
        logic [32:0] r;
        r = ref_op(req_op_i[w], req_a_i[w], req_b_i[w]);
        e_cur.idx = w; e_cur.err = r[32]; e_cur.data = r[31:0];
        e_cur.a = req_a_i[w]; e_cur.b = req_b_i[w];
        e_cur.sgn = (req_op_i[w] == OP_DIV) || (req_op_i[w] == OP_REM);
        e_cur.rem = (req_op_i[w] == OP_REM);
        e_cur.special = r[32] || (req_b_i[w] == 0) ||
                        (e_cur.sgn && req_a_i[w] == INT_MIN && req_b_i[w] == 32'hFFFF_FFFF);
        e_cur.gcyc = cyc;
        sb.push_back(e_cur);
        m_ptr = w; m_idle = 1'b0; busy_cnt = 0;
        last_gnt_cyc = cyc; last_gnt_idx = w;
      end

      if (sb.size() > 0 && sb[0].special) chk("div_unused", 64'(div_valid_o), 64'd0);
      if (div_valid_o) begin
        if (sb.size() == 0) flag("issue_without_op");
        else begin
          if (!prev_dv) chk("issue_latency", 64'(cyc), 64'(sb[0].gcyc + 1));
          chk("issue_a", 64'(div_a_o), 64'(sb[0].a));
          chk("issue_b", 64'(div_b_o), 64'(sb[0].b));
          chk("issue_flags", 64'({div_signed_o, div_rem_o}), 64'({sb[0].sgn, sb[0].rem}));
        end
      end
      prev_dv = div_valid_o;

      if (div_done_i) begin
        div_pend = 1'b0;
        done_cyc = cyc;
      end
      if (div_valid_o && div_ready_i) begin
        if (bp_acc_cyc != 0) chk("bp_accept_cycle", 64'(cyc), 64'(bp_acc_cyc));
        div_pend    = 1'b1;
        div_done_at = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 12)));
        div_res     = dmodel(div_a_o, div_b_o, div_signed_o, div_rem_o);
      end

      if (|rsp_valid_o) begin
        if (sb.size() == 0) flag("unexpected_response");
        else begin
          e_cur = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid_o), 64'(N_REQ'(1) << e_cur.idx));
          chk("rsp_data", 64'(rsp_data_o), 64'(e_cur.data));
          chk("rsp_err", 64'(rsp_err_o), 64'(e_cur.err));
          chk("rsp_latency", 64'(cyc), 64'(e_cur.special ? e_cur.gcyc + 1 : done_cyc + 1));
          last_data = e_cur.data; last_err = e_cur.err; rsp_cyc = cyc;
        end
      end else begin
        chk("rsp_hold", 64'({rsp_err_o, rsp_data_o}), 64'({last_err, last_data}));
      end

      if (!m_idle) busy_cnt++;
      if (busy_cnt > 200) begin
        flag("timeout_waiting_response");
        sb.delete(); m_idle = 1'b1; busy_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      tick();
      if (m_idle && sb.size() == 0) break;
    end
  endtask

  task automatic one(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid_i[i] = 1'b1; req_op_i[i] = op; req_a_i[i] = a; req_b_i[i] = b;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (last_gnt_cyc == cyc - 1) break;
    end
    req_valid_i[i] = 1'b0;
    wait_idle();
  endtask

  task automatic new_req(input int i);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 3) req_op_i[i] = OP_DIV;
    else if (r < 6) req_op_i[i] = OP_DIVU;
    else if (r < 9) req_op_i[i] = OP_REM;
    else begin
      req_op_i[i] = 4'($urandom);
      if (req_op_i[i] == OP_DIV || req_op_i[i] == OP_DIVU || req_op_i[i] == OP_REM) req_op_i[i] = 4'b0000;
    end
    case ($urandom_range(0, 7))
      0: req_a_i[i] = INT_MIN;
      1: req_a_i[i] = $urandom_range(0, 200);
      2: req_a_i[i] = -$urandom_range(0, 200);
      default: req_a_i[i] = $urandom;
    endcase
    case ($urandom_range(0, 7))
      0: req_b_i[i] = 32'd0;
      1: req_b_i[i] = 32'hFFFF_FFFF;
      2: req_b_i[i] = $urandom_range(1, 20);
      3: req_b_i[i] = -$urandom_range(1, 20);
      default: req_b_i[i] = $urandom;
    endcase
    req_valid_i[i] = 1'b1;
  endtask

  initial begin
    int gcount;
    repeat (3) tick();
    rst_i = 1'b0;
    repeat (2) tick();

    // Directed cases.
    one(5, OP_DIVU, 32'd100, 32'd7);
    one(2, OP_DIV, -32'sd9, 32'd0);
    one(3, OP_REM, -32'sd9, 32'd0);
    one(4, OP_DIV, INT_MIN, 32'hFFFF_FFFF);
    one(6, OP_REM, INT_MIN, 32'hFFFF_FFFF);
    one(1, 4'b0000, 32'd3, 32'd4);
    ready_block_until = cyc + 6;
    bp_acc_cyc = cyc + 6;
    one(8, OP_DIV, -32'sd1000, 32'd33);
    bp_acc_cyc = 0;
    ready_block_until = 0;

    // Fairness from a fresh pointer: all PEs hold their requests.
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    lat_fixed = 2;
    for (int i = 0; i < N_REQ; i++) begin
      req_valid_i[i] = 1'b1; req_op_i[i] = OP_DIVU;
      req_a_i[i] = $urandom; req_b_i[i] = $urandom_range(1, 1000);
    end
    gcount = 0;
    for (int k = 0; k < 2000 && gcount < 33; k++) begin
      tick();
      if (last_gnt_cyc == cyc - 1) begin
        gcount++;
        req_a_i[last_gnt_idx] = $urandom;
        req_b_i[last_gnt_idx] = $urandom_range(1, 1000);
      end
    end
    req_valid_i = '0;
    wait_idle();

    // Random traffic with random ready and divider latency.
    lat_fixed = 0;
    ready_rand = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (last_gnt_cyc == cyc - 1 && last_gnt_idx == i) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else req_valid_i[i] = 1'b0;
        end else if (!req_valid_i[i]) begin
          if ($urandom_range(0, 15) == 0) new_req(i);
        end else if ($urandom_range(0, 99) == 0) begin
          req_valid_i[i] = 1'b0;
        end
      end
    end
    req_valid_i = '0;
    wait_idle();

    // Reset while waiting on the divider; the late done must be ignored.
    ready_rand = 1'b0;
    lat_fixed = 20;
    req_valid_i[7] = 1'b1; req_op_i[7] = OP_DIVU; req_a_i[7] = 32'd5000; req_b_i[7] = 32'd9;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (last_gnt_cyc == cyc - 1) break;
    end
    req_valid_i[7] = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (30) tick();
    lat_fixed = 3;
    one(9, OP_DIVU, 32'd77, 32'd7);
    req_valid_i[9] = 1'b1; req_op_i[9] = OP_REM; req_a_i[9] = 32'd50; req_b_i[9] = 32'd7;
    req_valid_i[3] = 1'b1; req_op_i[3] = OP_DIV; req_a_i[3] = -32'sd50; req_b_i[3] = 32'd7;
    repeat (3) tick();
    req_valid_i = '0;
    wait_idle();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pea_div_arbiter.md
Name: pea_div_arbiter

Overview:
- Shares one iterative radix-16 divider (N_DIV_STAGE stages, external) among all PEs of the M x N PEA that execute DIV, DIVU or REM.
- Round-robin arbitration selects one requester, captures its operands and issues them to the divider.
- Collects the result and returns it to the winning PE.
- Resolves divide-by-zero and signed overflow locally, without using the divider.

Parameters:
- N_REQ, 16 (M*N): number of requesting PEs.
- N_BITS, 32: operand/result width.
- OP_W, 4: opcode width, carrying fu_instr_t encoding.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  N_REQ  per-PE request; held until grant
- req_op_i  in  N_REQ x OP_W  per-PE opcode (DIV=4'b1011, DIVU=4'b1100, REM=4'b1110)
- req_a_i  in  N_REQ x N_BITS  per-PE dividend
- req_b_i  in  N_REQ x N_BITS  per-PE divisor
- grant_o  out  N_REQ  one-hot, 1-cycle pulse; operands captured this cycle
- rsp_valid_o  out  N_REQ  one-hot, 1-cycle result pulse
- rsp_data_o  out  N_BITS  result, valid with rsp_valid_o
- rsp_err_o  out  1  unsupported opcode flag, valid with rsp_valid_o
- busy_o  out  1  high whenever state != IDLE
- div_valid_o  out  1  issue request to divider
- div_ready_i  in  1  divider accepts the issue
- div_a_o, div_b_o  out  N_BITS  latched operands
- div_signed_o  out  1  1 for DIV/REM
- div_rem_o  out  1  1 for REM
- div_done_i  in  1  divider result valid, 1-cycle pulse
- div_result_i  in  N_BITS  divider result

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset, including mid-operation:
  - State goes to IDLE and every output goes to 0.
  - RR pointer resets to N_REQ-1, so requester 0 has first priority.
  - Any in-flight divider operation is abandoned; a later div_done_i is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, the winner w is the first set bit searching ptr+1, ptr+2, ... with modulo-N_REQ wrap.
  - In the same cycle (Mealy): grant_o[w]=1; op/a/b/w are latched; ptr<=w.
  - Next state by case:
    - Unsupported opcode: result 0, err=1, -> RESP.
    - b==0: result all-ones for DIV/DIVU, result a for REM; -> RESP.
    - DIV/REM with a==32'h8000_0000 and b==all-ones: DIV gives 32'h8000_0000, REM gives 0; -> RESP.
    - Otherwise -> ISSUE.
- ISSUE:
  - div_valid_o=1, with div_a_o/div_b_o/div_signed_o/div_rem_o stable.
  - When div_ready_i=1, go to WAIT next cycle.
- WAIT:
  - div_valid_o=0.
  - On div_done_i, latch div_result_i and go to RESP.
  - div_done_i in any other state is ignored.
- RESP: rsp_valid_o[w]=1 with the latched data/err for one cycle, then -> IDLE. No arbitration happens in this cycle.
- Latency:
  - Special case: grant at T, response at T+1.
  - Normal: grant at T, div_valid_o at T+1; if ready at T+1 and done at T+1+k, response at T+2+k.
- Requester rules:
  - Only one operation is in flight at a time.
  - A PE may drop req_valid_i before it is granted; no grant results.
  - A PE may change operands only after its grant.
  - req_valid_i still high after the response is treated as a new request and is arbitrated with fairness from ptr.
- When rsp_valid_o is 0, rsp_data_o and rsp_err_o hold their last values; they are 0 after reset.

Test Plan:
- Single request: PE5 DIVU a=100, b=7; divider returns 14 after 8 cycles -> grant_o=1<<5 at T, div_valid_o at T+1, rsp_valid_o[5] with 14 at T+10.
- Fairness: all 16 PEs hold valid continuously -> grants in order 0,1,...,15,0; each PE is served once per 16 operations; no grant is issued while busy_o=1.
- Divide-by-zero: PE2 DIV a=-9, b=0 -> response 32'hFFFF_FFFF at T+1, div_valid_o never asserted. PE3 REM a=-9, b=0 -> response 32'hFFFF_FFF7.
- Overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM of the same operands -> 0; divider unused.
- Backpressure and errors:
  - Hold div_ready_i=0 for 5 cycles -> div_valid_o stays high with stable operands; accepted on the first ready cycle.
  - Opcode ADD -> rsp_err_o=1, data 0.
- Reset while in WAIT -> all outputs 0 next cycle; the subsequent div_done_i is ignored; next grant goes to the lowest valid index.
